alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage directly downstream of the ALU decoder: consumes ALUControl/FlagW, runs the op on SrcA/SrcB.
//  Holds the architectural NZCV flag register for the condition logic.
//  Shifts (LSL/LSR/ASR/ROR) are iterative, 1 bit/cycle; all other ops complete in 1 cycle.
//  Valid/ready handshake on both sides; one op in flight at a time.
// PARAMETERS
//  WIDTH    32  datapath width
//  SHAMT_W  5   shift-amount width
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        synchronous, active-high
//  in_valid    in   1        operation offered
//  in_ready    out  1        unit can accept (high only in IDLE)
//  ALUControl  in   4        op code from ALU decoder
//  FlagW       in   2        [1]=write N,Z; [0]=write C,V
//  SrcA        in   WIDTH    operand A
//  SrcB        in   WIDTH    operand B / shift source
//  ShAmt       in   SHAMT_W  shift amount
//  out_valid   out  1        ALUResult valid
//  out_ready   in   1        consumer takes result
//  ALUResult   out  WIDTH    result, stable while out_valid
//  ALUFlags    out  4        registered {N,Z,C,V}
// BEHAVIOUR
//  Reset (sync, active-high, any state): state=IDLE, in_ready=1, out_valid=0, ALUResult=0, ALUFlags=4'b0000.
//  Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 XOR, 0101 NOT(~SrcB), 0111 LSL, 1000 LSR,
//   1001 ASR, 1010 ROR, 1011 CMP (SrcA-SrcB). Unused codes (0110, 11xx): result 0, 1-cycle.
//  Accept on in_valid&&in_ready (cycle T); ALUControl/FlagW/operands/ShAmt latched at T.
//  FSM IDLE->DONE for non-shifts and ShAmt==0; IDLE->SHIFT for shifts with ShAmt!=0.
//  SHIFT: counter loaded with ShAmt, one 1-bit step per cycle, decrement; at count 1 -> DONE.
//   out_valid rises at T+1 (non-shift / ShAmt==0) or T+ShAmt+1 (shift).
//  DONE: out_valid=1, ALUResult held; on out_ready -> IDLE (in_ready high next cycle, no same-cycle accept).
//  Arithmetic mod 2^WIDTH. ADD: C=carry-out, V=signed overflow. SUB/CMP: C=NOT borrow, V=signed overflow.
//  N=result[WIDTH-1], Z=(result==0) for every op.
//  Shift C = last bit shifted out; ShAmt==0 -> result=SrcB, C keeps current flag value.
//  LSL/LSR zero-fill, ASR sign-fill, ROR rotate; logic ops/unused codes: C,V = current flag values.
//  Flag register written only on the DONE handshake (out_valid&&out_ready), masked by latched FlagW.
//  Backpressure: result, next-flags and ALUFlags frozen while out_ready=0.
//  Reset mid-SHIFT/DONE: op dropped, no flag write, no out_valid.
// CONFIGURATION
//  ALU_EXEC_FAST_SHIFT_EN defined: shifts use combinational barrel shifter, always IDLE->DONE,
//   out_valid at T+1; SHIFT state and counter not built.
//  Undefined: iterative shifter as above. Result/flag values identical in both builds.
// STRUCTURE
//  Package alu_exec_pkg: alu_ctrl_e enum (codes above), exec_state_e {IDLE,SHIFT,DONE},
//   FLAG_N/Z/C/V index constants, FLAGW_NZ/FLAGW_CV bit constants.
//  Sub-module alu_shift_step: one-bit LSL/LSR/ASR/ROR step, returns value + carry-out;
//   instantiated once (iterative) or WIDTH-chained via generate under ALU_EXEC_FAST_SHIFT_EN.
// TESTING
//  ADD 0x7FFFFFFF+0x1, FlagW=11 -> out_valid at T+1, ALUResult 0x80000000, after handshake ALUFlags=1001.
//  SUB 5-5, FlagW=11 -> ALUResult 0, ALUFlags=0110; CMP 3-5, FlagW=10 -> 0xFFFFFFFE, N=1, Z=0, C/V unchanged.
//  LSR SrcB=0x80000001 ShAmt=4, FlagW=10 -> out_valid at T+5 (T+1 with FAST), 0x08000000, N=0 Z=0, C/V unchanged.
//  ROR SrcB=0x12345678 ShAmt=0 -> out_valid at T+1, ALUResult 0x12345678, flags C unchanged.
//  out_ready low 3 cycles in DONE -> ALUResult/ALUFlags stable, in_ready=0; flags update cycle after handshake.
//  reset high during SHIFT (ShAmt=20) -> next cycle in_ready=1, out_valid=0, ALUFlags=0000, no stray result.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute stage.
// Includes op codes, FSM states, and flag bit positions.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_LSL = 4'b0111,
    OP_LSR = 4'b1000,
    OP_ASR = 4'b1001,
    OP_ROR = 4'b1010,
    OP_CMP = 4'b1011
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } exec_state_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside FlagW
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/alu_exec_unit_shift_step.sv
// One-bit LSL/LSR/ASR/ROR step with carry-out (the bit shifted out).
// Any other op code passes the value through unchanged, with carry 0.
module alu_shift_step
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val,
  output logic             o_carry
);

  always_comb begin
    o_val   = i_val;
    o_carry = 1'b0;
    case (i_op)
      OP_LSL: begin
        o_val   = {i_val[WIDTH-2:0], 1'b0};
        o_carry = i_val[WIDTH-1];
      end
      OP_LSR: begin
        o_val   = {1'b0, i_val[WIDTH-1:1]};
        o_carry = i_val[0];
      end
      OP_ASR: begin
        o_val   = {i_val[WIDTH-1], i_val[WIDTH-1:1]};
        o_carry = i_val[0];
      end
      OP_ROR: begin
        o_val   = {i_val[0], i_val[WIDTH-1:1]};
        o_carry = i_val[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: valid/ready wrapped ALU with NZCV flag register and shifter.
// Define ALU_EXEC_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the 1 bit/cycle one.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUControl,
  input  logic [1:0]         FlagW,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  input  logic [SHAMT_W-1:0] ShAmt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   ALUResult,
  output logic [3:0]         ALUFlags
);

  exec_state_e      r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic [1:0]       r_flagw;
  logic             r_c;
  logic             r_v;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_c;
  logic             w_v;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  localparam int NSTEP = (2 ** SHAMT_W) - 1;
  logic [WIDTH-1:0] w_chain [0:NSTEP];
  logic             w_chc   [0:NSTEP];

  assign w_chain[0] = SrcB;
  assign w_chc[0]   = 1'b0;
  for (genvar g = 0; g < NSTEP; g++) begin : g_step
    alu_shift_step #(.WIDTH(WIDTH)) u_step (
      .i_op    (ALUControl),
      .i_val   (w_chain[g]),
      .o_val   (w_chain[g+1]),
      .o_carry (w_chc[g+1])
    );
  end
`else
  logic [3:0]         r_op;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   w_step_val;
  logic               w_step_c;
  logic               w_is_shift;

  assign w_is_shift = (ALUControl == OP_LSL) || (ALUControl == OP_LSR) ||
                      (ALUControl == OP_ASR) || (ALUControl == OP_ROR);

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .i_op    (r_op),
    .i_val   (r_result),
    .o_val   (w_step_val),
    .o_carry (w_step_c)
  );
`endif

  // Result/C/V as known at accept time; iterative shifts start from SrcB and refine in SHIFT
  always_comb begin
    w_res = '0;
    w_sum = '0;
    w_c   = r_flags[FLAG_C];
    w_v   = r_flags[FLAG_V];
    case (ALUControl)
      OP_ADD: begin
        w_sum = {1'b0, SrcA} + {1'b0, SrcB};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_sum = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_res[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND: w_res = SrcA & SrcB;
      OP_ORR: w_res = SrcA | SrcB;
      OP_XOR: w_res = SrcA ^ SrcB;
      OP_NOT: w_res = ~SrcB;
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
`ifdef ALU_EXEC_FAST_SHIFT_EN
        w_res = w_chain[ShAmt];
        w_c   = (ShAmt == '0) ? r_flags[FLAG_C] : w_chc[ShAmt];
`else
        w_res = SrcB;
`endif
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_flagw     <= '0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
      r_op        <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_flagw    <= FlagW;
            r_result   <= w_res;
            r_c        <= w_c;
            r_v        <= w_v;
            r_in_ready <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            r_op       <= ALUControl;
            if (w_is_shift && (ShAmt != '0)) begin
              r_state <= SHIFT;
              r_cnt   <= ShAmt;
            end else
`endif
            begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
`ifndef ALU_EXEC_FAST_SHIFT_EN
        SHIFT: begin
          r_result <= w_step_val;
          r_c      <= w_step_c;
          r_cnt    <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            if (r_flagw[FLAGW_NZ]) begin
              r_flags[FLAG_N] <= r_result[WIDTH-1];
              r_flags[FLAG_Z] <= (r_result == '0);
            end
            if (r_flagw[FLAGW_CV]) begin
              r_flags[FLAG_C] <= r_c;
              r_flags[FLAG_V] <= r_v;
            end
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign ALUFlags  = r_flags;

endmodule
